// File: rtl/spi_ram_cache_pkg.sv
// Shared types and helpers for the SPI RAM word cache.
package spi_ram_cache_pkg;

    // Width of one cached word (the core only issues 16-bit accesses).
    localparam int DATA_BITS = 16;

    // Width of the hit/miss statistics counters.
    localparam int STAT_BITS = 16;

    // Controller-side sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_WR_ISSUE = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_WAIT     = 3'd4
    } state_t;

    // Tag width: everything above the line index.
    function automatic int tag_bits(input int addr_bits, input int index_bits);
        return addr_bits - index_bits;
    endfunction

endpackage

// File: rtl/spi_ram_cache_lines.sv
// Valid/tag/data storage for the direct-mapped word cache.
// Two combinational lookups (request line and the A+1 neighbour), one write
// port, and two valid-clear ports used to drop words overlapping a write.
module spi_ram_cache_lines
    import spi_ram_cache_pkg::*;
#(
    parameter  int ADDR_BITS  = 16,
    parameter  int INDEX_BITS = 3,
    localparam int TAG_BITS   = tag_bits(ADDR_BITS, INDEX_BITS),
    localparam int LINES      = 1 << INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] lk_idx_i,
    output logic                  lk_valid_o,
    output logic [TAG_BITS-1:0]   lk_tag_o,
    output logic [DATA_BITS-1:0]  lk_data_o,
    input  logic [INDEX_BITS-1:0] nb_idx_i,
    output logic                  nb_valid_o,
    output logic [TAG_BITS-1:0]   nb_tag_o,
    input  logic                  wr_en_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic [TAG_BITS-1:0]   wr_tag_i,
    input  logic [DATA_BITS-1:0]  wr_data_i,
    input  logic                  clr_prev_en_i,
    input  logic [INDEX_BITS-1:0] clr_prev_idx_i,
    input  logic                  clr_next_en_i,
    input  logic [INDEX_BITS-1:0] clr_next_idx_i
);

    logic [LINES-1:0]     valid_q;
    logic [TAG_BITS-1:0]  tag_q  [LINES];
    logic [DATA_BITS-1:0] data_q [LINES];

    assign lk_valid_o = valid_q[lk_idx_i];
    assign lk_tag_o   = tag_q[lk_idx_i];
    assign lk_data_o  = data_q[lk_idx_i];
    assign nb_valid_o = valid_q[nb_idx_i];
    assign nb_tag_o   = tag_q[nb_idx_i];

    // Valid bits: cleared on reset; the line write wins over a neighbour clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            if (clr_prev_en_i) valid_q[clr_prev_idx_i] <= 1'b0;
            if (clr_next_en_i) valid_q[clr_next_idx_i] <= 1'b0;
            if (wr_en_i)       valid_q[wr_idx_i]       <= 1'b1;
        end
    end

    // Tag and data payload; meaningless until the valid bit is set, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/spi_ram_word_cache.sv
// Direct-mapped, write-through word cache in front of spi_ram_controller.
// Keyed on the full byte address; a write invalidates cached words at A-1
// and A+1 since they share a byte with the written word.
// Optional: define SPI_RAM_WORD_CACHE_STATS_EN for hit_count/miss_count outputs.
module spi_ram_word_cache
    import spi_ram_cache_pkg::*;
#(
    parameter int ADDR_BITS  = 16,
    parameter int INDEX_BITS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] addr_in,
    input  logic [15:0]          data_in,
    input  logic                 start_read,
    input  logic                 start_write,
    output logic [15:0]          data_out,
    output logic                 busy,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [15:0]          mem_data_in,
    output logic                 mem_start_read,
    output logic                 mem_start_write,
    input  logic [15:0]          mem_data_out,
    input  logic                 mem_busy
`ifdef SPI_RAM_WORD_CACHE_STATS_EN
    ,
    output logic [15:0]          hit_count,
    output logic [15:0]          miss_count
`endif
);

    localparam int TAG_BITS = tag_bits(ADDR_BITS, INDEX_BITS);

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [DATA_BITS-1:0]   wdata_q, wdata_d;
    logic [DATA_BITS-1:0]   dout_q, dout_d;
    logic                   op_wr_q, op_wr_d;
    logic                   busy_q;
    logic                   fill_en;
    logic                   rd_hit_acc, rd_miss_acc;

    logic [ADDR_BITS-1:0]   addr_prev, addr_next;
    logic [INDEX_BITS-1:0]  lk_idx;
    logic                   lk_valid, nb_valid;
    logic [TAG_BITS-1:0]    lk_tag, nb_tag;
    logic [DATA_BITS-1:0]   lk_data;
    logic                   hit;
    logic                   wr_en, clr_prev_en, clr_next_en;
    logic [DATA_BITS-1:0]   wr_data;

    // Neighbour addresses wrap modulo 2^ADDR_BITS.
    assign addr_prev = addr_q - ADDR_BITS'(1);
    assign addr_next = addr_q + ADDR_BITS'(1);

    // Port 0 serves the core request in IDLE and the A-1 check during WR_ISSUE.
    assign lk_idx = (state_q == ST_WR_ISSUE) ? addr_prev[INDEX_BITS-1:0]
                                             : addr_in[INDEX_BITS-1:0];
    assign hit    = lk_valid && (lk_tag == addr_in[ADDR_BITS-1:INDEX_BITS]);

    assign clr_prev_en = (state_q == ST_WR_ISSUE) && lk_valid &&
                         (lk_tag == addr_prev[ADDR_BITS-1:INDEX_BITS]);
    assign clr_next_en = (state_q == ST_WR_ISSUE) && nb_valid &&
                         (nb_tag == addr_next[ADDR_BITS-1:INDEX_BITS]);

    // Write-allocate in WR_ISSUE, read fill when the controller returns data.
    assign wr_en   = (state_q == ST_WR_ISSUE) || fill_en;
    assign wr_data = op_wr_q ? wdata_q : mem_data_out;

    spi_ram_cache_lines #(
        .ADDR_BITS  (ADDR_BITS),
        .INDEX_BITS (INDEX_BITS)
    ) u_lines (
        .clk            (clk),
        .rst            (rst),
        .lk_idx_i       (lk_idx),
        .lk_valid_o     (lk_valid),
        .lk_tag_o       (lk_tag),
        .lk_data_o      (lk_data),
        .nb_idx_i       (addr_next[INDEX_BITS-1:0]),
        .nb_valid_o     (nb_valid),
        .nb_tag_o       (nb_tag),
        .wr_en_i        (wr_en),
        .wr_idx_i       (addr_q[INDEX_BITS-1:0]),
        .wr_tag_i       (addr_q[ADDR_BITS-1:INDEX_BITS]),
        .wr_data_i      (wr_data),
        .clr_prev_en_i  (clr_prev_en),
        .clr_prev_idx_i (addr_prev[INDEX_BITS-1:0]),
        .clr_next_en_i  (clr_next_en),
        .clr_next_idx_i (addr_next[INDEX_BITS-1:0])
    );

    // Next-state and datapath selection; a write request beats a read request.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        op_wr_d     = op_wr_q;
        dout_d      = dout_q;
        fill_en     = 1'b0;
        rd_hit_acc  = 1'b0;
        rd_miss_acc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_write) begin
                    addr_d  = addr_in;
                    wdata_d = data_in;
                    op_wr_d = 1'b1;
                    state_d = ST_WR_ISSUE;
                end else if (start_read) begin
                    if (hit) begin
                        dout_d     = lk_data;
                        rd_hit_acc = 1'b1;
                    end else begin
                        addr_d      = addr_in;
                        op_wr_d     = 1'b0;
                        state_d     = ST_RD_ISSUE;
                        rd_miss_acc = 1'b1;
                    end
                end
            end
            ST_RD_ISSUE, ST_WR_ISSUE: state_d = ST_SETTLE;
            ST_SETTLE:                state_d = ST_WAIT;
            ST_WAIT: begin
                if (!mem_busy) begin
                    state_d = ST_IDLE;
                    if (!op_wr_q) begin
                        dout_d  = mem_data_out;
                        fill_en = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers and the registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            dout_q  <= '0;
            op_wr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
            dout_q  <= dout_d;
            op_wr_q <= op_wr_d;
        end
    end

    // Latched request address/data; only observed outside IDLE.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign data_out        = dout_q;
    assign busy            = busy_q;
    assign mem_start_read  = (state_q == ST_RD_ISSUE);
    assign mem_start_write = (state_q == ST_WR_ISSUE);
    assign mem_addr        = (state_q != ST_IDLE) ? addr_q : '0;
    assign mem_data_in     = ((state_q != ST_IDLE) && op_wr_q) ? wdata_q : '0;

`ifdef SPI_RAM_WORD_CACHE_STATS_EN
    logic [STAT_BITS-1:0] hit_cnt_q, miss_cnt_q;

    function automatic logic [STAT_BITS-1:0] sat_inc(input logic [STAT_BITS-1:0] v);
        return (v == {STAT_BITS{1'b1}}) ? v : v + STAT_BITS'(1);
    endfunction

    // Read hit/miss counters, bumped once at request acceptance, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (rd_hit_acc)  hit_cnt_q  <= sat_inc(hit_cnt_q);
            if (rd_miss_acc) miss_cnt_q <= sat_inc(miss_cnt_q);
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_spi_ram_word_cache.sv
// Bench for spi_ram_word_cache: a byte-addressed RAM behind a simple
// controller model, a transaction-level cache model, and a per-cycle monitor.
module tb_spi_ram_word_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr_in, data_in;
    logic        start_read, start_write;
    logic [15:0] data_out;
    logic        busy;
    logic [15:0] mem_addr, mem_data_in;
    logic        mem_start_read, mem_start_write;
    logic [15:0] mem_data_out;
    logic        mem_busy;
`ifdef SPI_RAM_WORD_CACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    spi_ram_word_cache dut (
        .clk             (clk),
        .rst             (rst),
        .addr_in         (addr_in),
        .data_in         (data_in),
        .start_read      (start_read),
        .start_write     (start_write),
        .data_out        (data_out),
        .busy            (busy),
        .mem_addr        (mem_addr),
        .mem_data_in     (mem_data_in),
        .mem_start_read  (mem_start_read),
        .mem_start_write (mem_start_write),
        .mem_data_out    (mem_data_out),
        .mem_busy        (mem_busy)
`ifdef SPI_RAM_WORD_CACHE_STATS_EN
        ,
        .hit_count       (hit_count),
        .miss_count      (miss_count)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- RAM and controller model ----------------
    bit [7:0] ram   [65536];
    bit       ram_w [65536];
    int       lat_cfg = 6;
    logic [15:0] c_addr;
    logic        c_rd;
    int          c_cnt;

    function automatic logic [7:0] rbyte(input logic [15:0] a);
        if (ram_w[a]) return ram[a];
        if (a == 16'h0010) return 8'hEF;
        if (a == 16'h0011) return 8'hBE;
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Little-endian word at byte address a; the upper byte wraps at 0xFFFF.
    function automatic logic [15:0] rword(input logic [15:0] a);
        logic [15:0] a1;
        a1 = a + 16'd1;
        return {rbyte(a1), rbyte(a)};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mem_busy     <= 1'b0;
            c_cnt        <= 0;
            mem_data_out <= 16'h0;
        end else if (mem_start_read || mem_start_write) begin
            mem_busy     <= 1'b1;
            c_cnt        <= lat_cfg;
            c_addr       <= mem_addr;
            c_rd         <= mem_start_read;
            mem_data_out <= 16'($urandom);
            if (mem_start_write) begin
                ram[mem_addr]           <= mem_data_in[7:0];
                ram[mem_addr + 16'd1]   <= mem_data_in[15:8];
                ram_w[mem_addr]         <= 1'b1;
                ram_w[mem_addr + 16'd1] <= 1'b1;
            end
        end else if (mem_busy) begin
            c_cnt <= c_cnt - 1;
            if (c_cnt <= 1) begin
                mem_busy     <= 1'b0;
                mem_data_out <= c_rd ? rword(c_addr) : 16'($urandom);
            end else begin
                mem_data_out <= 16'($urandom);
            end
        end
    end

    // ---------------- cache model (transaction level) ----------------
    bit          mv [8];
    logic [15:0] ma [8];
    int          m_hits = 0, m_misses = 0;
    int          n_rd = 0, n_wr = 0;
    logic [15:0] last_rd_addr, last_wr_addr, last_wr_data;
    int          last_bc;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Per-cycle monitor: counts controller pulses and checks idle outputs.
    task automatic monitor();
        logic prev_r, prev_w;
        prev_r = 1'b0;
        prev_w = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_start_read === 1'b1) begin
                n_rd++;
                last_rd_addr = mem_addr;
            end
            if (mem_start_write === 1'b1) begin
                n_wr++;
                last_wr_addr = mem_addr;
                last_wr_data = mem_data_in;
            end
            if (!rst) begin
                if (busy === 1'b0)
                    check("idle_mem_outputs", {mem_start_read, mem_start_write, mem_addr, mem_data_in}, 64'h0);
                if (prev_r) check("rd_pulse_one_cycle", mem_start_read, 0);
                if (prev_w) check("wr_pulse_one_cycle", mem_start_write, 0);
            end
            prev_r = mem_start_read;
            prev_w = mem_start_write;
        end
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 1;
        while (busy === 1'b1 && cycles < 300) begin
            tick();
            if (busy === 1'b1) cycles++;
        end
        check("busy_returns_low", busy, 0);
    endtask

    task automatic do_read(input logic [15:0] a, output bit missed);
        int rd0, bc, idx;
        bit mhit;
        rd0  = n_rd;
        idx  = int'(a[2:0]);
        mhit = mv[idx] && (ma[idx] == a);
        addr_in    = a;
        start_read = 1'b1;
        tick();
        start_read = 1'b0;
        addr_in    = 16'($urandom);
        if (mhit) begin
            check("hit_busy_low", busy, 0);
            check("hit_data", data_out, rword(a));
            tick();
            check("hit_no_mem_read", n_rd - rd0, 0);
            missed = 1'b0;
            m_hits++;
        end else begin
            check("miss_busy_high", busy, 1);
            wait_idle(bc);
            last_bc = bc;
            check("miss_data", data_out, rword(a));
            check("miss_one_mem_read", n_rd - rd0, 1);
            check("miss_mem_addr", last_rd_addr, a);
            mv[idx] = 1'b1;
            ma[idx] = a;
            missed  = 1'b1;
            m_misses++;
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input bit with_read);
        int wr0, rd0, bc;
        logic [15:0] dprev, am1, ap1;
        wr0   = n_wr;
        rd0   = n_rd;
        dprev = data_out;
        addr_in     = a;
        data_in     = d;
        start_write = 1'b1;
        start_read  = with_read;
        tick();
        start_write = 1'b0;
        start_read  = 1'b0;
        check("wr_busy_high", busy, 1);
        wait_idle(bc);
        check("wr_one_mem_write", n_wr - wr0, 1);
        check("wr_no_mem_read", n_rd - rd0, 0);
        check("wr_mem_addr", last_wr_addr, a);
        check("wr_mem_data", last_wr_data, d);
        check("wr_data_out_held", data_out, dprev);
        check("wr_ram_word", rword(a), d);
        am1 = a - 16'd1;
        ap1 = a + 16'd1;
        for (int i = 0; i < 8; i++)
            if (mv[i] && (ma[i] == am1 || ma[i] == ap1)) mv[i] = 1'b0;
        mv[a[2:0]] = 1'b1;
        ma[a[2:0]] = a;
    endtask

    initial begin
        bit m;
        rst = 1'b1; addr_in = '0; data_in = '0; start_read = 1'b0; start_write = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_busy", busy, 0);
        check("reset_data_out", data_out, 16'h0);
        check("reset_mem_outputs", {mem_start_read, mem_start_write, mem_addr, mem_data_in}, 64'h0);

        // Cold miss with a 6-cycle controller.
        lat_cfg = 6;
        do_read(16'h0010, m);
        check("cold_missed", m, 1);
        check("cold_data", data_out, 16'hBEEF);
        check("cold_busy_ge8", last_bc >= 8, 1);
        do_read(16'h0010, m);
        check("repeat_hit", m, 0);
        check("repeat_data", data_out, 16'hBEEF);

        // Conflict on index 0.
        do_read(16'h0018, m);
        check("conflict_a_missed", m, 1);
        check("conflict_a_data", data_out, 16'h4342);
        do_read(16'h0010, m);
        check("conflict_b_missed", m, 1);
        check("conflict_b_data", data_out, 16'hBEEF);

        // Write-allocate.
        do_write(16'h0020, 16'h1234, 1'b0);
        do_read(16'h0020, m);
        check("alloc_hit", m, 0);
        check("alloc_data", data_out, 16'h1234);

        // Overlap invalidation on both sides.
        do_read(16'h0040, m);
        do_read(16'h0042, m);
        do_write(16'h0041, 16'hA5C3, 1'b0);
        do_read(16'h0040, m);
        check("overlap_lo_missed", m, 1);
        check("overlap_lo_data", data_out, 16'hC31A);
        do_read(16'h0042, m);
        check("overlap_hi_missed", m, 1);
        check("overlap_hi_data", data_out, 16'h19A5);

        // Wrap-around neighbours.
        do_read(16'h0000, m);
        do_write(16'hFFFF, 16'h7788, 1'b0);
        do_read(16'h0000, m);
        check("wrap_next_missed", m, 1);
        check("wrap_next_data", data_out, 16'h5B77);
        do_write(16'h0000, 16'h1122, 1'b0);
        do_read(16'hFFFF, m);
        check("wrap_prev_missed", m, 1);
        check("wrap_prev_data", data_out, 16'h2288);

        // Simultaneous read and write: write wins.
        do_write(16'h0030, 16'h5555, 1'b1);
        do_read(16'h0030, m);
        check("prio_hit", m, 0);
        check("prio_data", data_out, 16'h5555);

        // Reset while waiting on a miss.
        begin
            int rd0;
            lat_cfg = 10;
            addr_in = 16'h0100; start_read = 1'b1;
            tick();
            start_read = 1'b0;
            repeat (4) tick();
            check("midop_busy_before", busy, 1);
            rd0 = n_rd;
            rst = 1'b1;
            tick();
            check("midop_busy_after", busy, 0);
            check("midop_data_out", data_out, 16'h0);
            rst = 1'b0;
            for (int i = 0; i < 8; i++) mv[i] = 1'b0;
            m_hits = 0; m_misses = 0;
            repeat (12) tick();
            check("midop_no_pulses", n_rd - rd0, 0);
            check("midop_stays_idle", busy, 0);
        end
        lat_cfg = 3;
        do_read(16'h0010, m);
        check("post_reset_missed", m, 1);
        do_read(16'h0010, m);
        do_read(16'h0010, m);
        do_read(16'h0018, m);
        do_read(16'h0018, m);
        check("stats_model_pin", {m_hits[15:0], m_misses[15:0]}, {16'd3, 16'd2});
`ifdef SPI_RAM_WORD_CACHE_STATS_EN
        check("stats_hits_3", hit_count, 16'd3);
        check("stats_misses_2", miss_count, 16'd2);
`endif

        // Randomised traffic over a small, overlapping address window.
        for (int t = 0; t < 300; t++) begin
            logic [15:0] a;
            int r;
            lat_cfg = $urandom_range(1, 5);
            a = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                            : 16'($urandom_range(0, 47));
            r = $urandom_range(0, 99);
            if (r < 25)      do_write(a, 16'($urandom), 1'b0);
            else if (r < 30) do_write(a, 16'($urandom), 1'b1);
            else             do_read(a, m);
        end
`ifdef SPI_RAM_WORD_CACHE_STATS_EN
        check("stats_hits_final", hit_count, 16'(m_hits));
        check("stats_misses_final", miss_count, 16'(m_misses));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_ram_word_cache.md
Name: spi_ram_word_cache

Overview:
- Direct-mapped, write-through word cache between the CPU core and spi_ram_controller.
- Upstream port mirrors the controller's request interface, so the core needs no change. Downstream port drives the controller.
- Read hits complete without SPI traffic, which removes most instruction-fetch stalls (PC reads, stack pops).
- Keyed on full byte address, because the core issues unaligned 16-bit accesses (PC+1).

Parameters:
- ADDR_BITS, 16, byte-address width on both sides.
- INDEX_BITS, 3, log2 of line count (8 lines, one 16-bit word each).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- addr_in  in  ADDR_BITS  core request byte address
- data_in  in  16  core write data
- start_read  in  1  core read request (sampled only in IDLE)
- start_write  in  1  core write request (sampled only in IDLE)
- data_out  out  16  read result, registered
- busy  out  1  high while a request is outstanding
- mem_addr  out  ADDR_BITS  to controller addr_in
- mem_data_in  out  16  to controller data_in
- mem_start_read  out  1  one-cycle pulse to controller
- mem_start_write  out  1  one-cycle pulse to controller
- mem_data_out  in  16  controller read data
- mem_busy  in  1  controller busy

Behaviour:
- Reset values: data_out=0, busy=0, mem_* outputs=0, all valid bits=0, state=IDLE.
- Line contents:
  - Line i holds valid, tag = addr[ADDR_BITS-1:INDEX_BITS], data[15:0].
  - Hit: valid and tag match at index = addr[INDEX_BITS-1:0].
- States: IDLE, RD_ISSUE, WR_ISSUE, SETTLE, WAIT.
- busy = (state != IDLE); it is registered.
- Read hit (IDLE, start_read, hit):
  - Next edge: data_out <= line data; stay IDLE; busy stays 0.
  - Result is valid the cycle after start_read, which is what the core's two-cycle fetch expects.
- Read miss (IDLE, start_read, miss):
  - Latch addr; go to RD_ISSUE (busy=1 the cycle after the request).
  - RD_ISSUE: mem_start_read=1 for exactly one cycle, mem_addr=latched addr -> SETTLE.
  - SETTLE: one cycle, letting the controller raise mem_busy -> WAIT.
  - WAIT: when mem_busy==0, data_out <= mem_data_out, fill the line (valid=1, tag, data) -> IDLE.
- Write (IDLE, start_write), hit or miss:
  - Latch addr and data -> WR_ISSUE.
  - WR_ISSUE: mem_start_write=1 for one cycle -> SETTLE -> WAIT.
  - WAIT: when mem_busy==0 -> IDLE; data_out unchanged.
  - Write-allocate: line[index(A)] <= {1, tag(A), data} in WR_ISSUE.
- Overlap coherence on write to address A:
  - In WR_ISSUE, clear valid of line[index(A-1)] if its tag equals tag(A-1).
  - Likewise line[index(A+1)] against tag(A+1).
  - Address arithmetic wraps modulo 2^ADDR_BITS (A=0x0000 checks 0xFFFF; A=0xFFFF checks 0x0000).
- Simultaneous start_read and start_write: write takes priority; the read is dropped.
- Requests while busy=1 are ignored; the core never issues them.
- mem_addr and mem_data_in hold the latched values from issue until return to IDLE; they are 0 in IDLE.
- Reset mid-operation: returns to IDLE and invalidates all lines; no further mem_start pulses. The controller is reset separately by the same reset.
- Only the core's word-sized accesses are supported (16-bit data fixed).

Optional Feature:
- Macro: SPI_RAM_WORD_CACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count[15:0] and miss_count[15:0]; both reset to 0.
  - Each read hit or read miss increments the matching counter once, at request acceptance in IDLE.
  - Counters saturate at 0xFFFF; writes are not counted.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package spi_ram_cache_pkg:
  - State encoding localparams (IDLE..WAIT).
  - TAG_BITS = ADDR_BITS-INDEX_BITS, as a function or localparam.
  - Line-struct field widths.
- Sub-module spi_ram_cache_lines:
  - Valid/tag/data arrays.
  - Two combinational lookup ports: request index, and the A+1 index for coherence.
  - One write port.
  - Valid-clear inputs for the A-1 and A+1 lines.
  - Synchronous clear on rst.

Test Plan:
- Cold read of 0x0010 with mem model returning 0xBEEF after 6 busy cycles -> busy high 8+ cycles, one mem_start_read pulse at 0x0010, data_out=0xBEEF, line valid.
- Repeat read of 0x0010 -> no mem_start_read, busy stays 0, data_out=0xBEEF the next cycle.
- Conflict: read 0x0018 (same index as 0x0010), then 0x0010 again -> both miss, two mem reads, correct data each time.
- Write 0x1234 to 0x0020 -> one mem_start_write with mem_data_in=0x1234; later read 0x0020 hits with 0x1234.
- Overlap: cache 0x0040 and 0x0042, then write 0x0041 -> both lines invalidated, later reads of 0x0040 and 0x0042 issue mem reads. Also write 0xFFFF with 0x0000 cached -> 0x0000 invalidated.
- Assert rst in WAIT of a miss -> next cycle busy=0, no fill, all lines invalid. With stats enabled: 3 hits and 2 misses yield hit_count=3, miss_count=2.
